// File: rtl/register_writeback_stage.sv
// Writeback stage: one-entry pipeline register ahead of the register file and flags
// register, with bypassed combinational read ports. Flags bits: [4]C [3]Z [2]N [1]V [0]P.
module register_writeback_stage #(
  parameter int DataWidth = 16,
  parameter int RegCount  = 8,
  parameter int AddrWidth = $clog2(RegCount),
  parameter int FlagWidth = 5
) (
  input  logic                 Clock,
  input  logic                 nReset,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic                 Hold,
  input  logic                 InWriteReg,
  input  logic                 InWriteFlags,
  input  logic [AddrWidth-1:0] InAddr,
  input  logic [DataWidth-1:0] InResult,
  input  logic [FlagWidth-1:0] InFlags,
  input  logic [AddrWidth-1:0] SrcAddr,
  input  logic [AddrWidth-1:0] DestAddr,
  output logic [DataWidth-1:0] OutSrc,
  output logic [DataWidth-1:0] OutDest,
  output logic [FlagWidth-1:0] OutFlags,
  output logic                 Busy
);

  logic                 p_valid;
  logic                 p_write_reg;
  logic                 p_write_flags;
  logic [AddrWidth-1:0] p_addr;
  logic [DataWidth-1:0] p_data;
  logic [FlagWidth-1:0] p_flags;

  logic [DataWidth-1:0] regs [RegCount];
  logic [FlagWidth-1:0] flags_q;

  logic capture;
  logic p_addr_ok;
  logic src_ok;
  logic dest_ok;
  logic src_hit;
  logic dest_hit;

  assign InReady  = ~Hold;
  assign capture  = InValid & ~Hold;
  assign Busy     = p_valid;

  assign p_addr_ok = int'(p_addr) < RegCount;
  assign src_ok    = int'(SrcAddr) < RegCount;
  assign dest_ok   = int'(DestAddr) < RegCount;
  assign src_hit   = p_valid & p_write_reg & (p_addr == SrcAddr);
  assign dest_hit  = p_valid & p_write_reg & (p_addr == DestAddr);

  // P lives exactly one cycle; a new capture may overlap the commit of the previous one.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      p_valid       <= 1'b0;
      p_write_reg   <= 1'b0;
      p_write_flags <= 1'b0;
      p_addr        <= '0;
      p_data        <= '0;
      p_flags       <= '0;
    end else begin
      p_valid <= capture;
      if (capture) begin
        p_write_reg   <= InWriteReg;
        p_write_flags <= InWriteFlags;
        p_addr        <= InAddr;
        p_data        <= InResult;
        p_flags       <= InFlags;
      end
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < RegCount; i++) begin
        regs[i] <= '0;
      end
      flags_q <= '0;
    end else if (p_valid) begin
      if (p_write_reg && p_addr_ok) begin
        regs[p_addr] <= p_data;
      end
      if (p_write_flags) begin
        flags_q <= p_flags;
      end
    end
  end

  // Bypass only from P, never from the In* ports, to keep the ALU loop registered.
  always_comb begin
    OutSrc = '0;
    if (src_ok) begin
      OutSrc = src_hit ? p_data : regs[SrcAddr];
    end
  end

  always_comb begin
    OutDest = '0;
    if (dest_ok) begin
      OutDest = dest_hit ? p_data : regs[DestAddr];
    end
  end

  assign OutFlags = (p_valid & p_write_flags) ? p_flags : flags_q;

endmodule
